// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
//
// Contents:
//   state_t          responder FSM states (IDLE, WAIT, RESP)
//   FUNCT3_*         access-size encodings on mem_funct3
//   byte_en()        byte-lane enables for a store of a given size/offset
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    // Any encoding that is not a byte or half access behaves as a full word.
    function automatic logic [3:0] byte_en(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3)
            FUNCT3_B, FUNCT3_BU: be = 4'b0001 << addr_lo;
            FUNCT3_H, FUNCT3_HU: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:             be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering between the core's right-aligned data
// and the little-endian 32-bit memory word.
//
// Ports:
//   funct3    in   access size / signedness
//   addr_lo   in   byte offset within the word (addr[1:0])
//   wr_data   in   right-aligned store data from the core
//   rd_word   in   raw word read from the array
//   be        out  byte enables for the store
//   wr_word   out  store data replicated onto every lane
//   ld_data   out  extracted and sign/zero-extended load result
module dmem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  be,
    output logic [31:0] wr_word,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;
    logic [15:0] half;

    assign be = byte_en(funct3, addr_lo);

    // Replicating the datum on all lanes lets the byte enables alone pick
    // the destination, so no shifter is needed on the store path.
    always_comb begin
        case (funct3)
            FUNCT3_B, FUNCT3_BU: wr_word = {4{wr_data[7:0]}};
            FUNCT3_H, FUNCT3_HU: wr_word = {2{wr_data[15:0]}};
            default:             wr_word = wr_data;
        endcase
    end

    assign shifted = rd_word >> {addr_lo, 3'b000};
    assign half    = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (funct3)
            FUNCT3_B:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            FUNCT3_BU: ld_data = {24'h0, shifted[7:0]};
            FUNCT3_H:  ld_data = {{16{half[15]}}, half};
            FUNCT3_HU: ld_data = {16'h0, half};
            default:   ld_data = rd_word;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store from the core, waits a
// fixed LATENCY, performs a byte/half/word access and pulses mem_ready.
//
// Optional feature macro: DMEM_ACCESS_FAULT_EN adds mem_fault and reports
// misaligned or out-of-range accesses instead of aligning/wrapping them.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   mem_rd_en    load request  (held by core until mem_ready)
//   mem_wr_en    store request (held by core until mem_ready; wins over load)
//   mem_addr     byte address
//   mem_wr_data  right-aligned store data
//   mem_funct3   access size/signedness
//   mem_rd_data  load result, zero except during the mem_ready cycle
//   mem_ready    one-cycle completion pulse
//   mem_busy     stall to the core
//   mem_fault    (macro only) access fault, coincident with mem_ready
//   dbg_state    current FSM state
//
// Handshake: a request is taken when the FSM is in IDLE and
// mem_rd_en|mem_wr_en is high; the core must hold all request signals
// stable until the cycle in which mem_ready is high, and mem_busy is high
// for every requesting cycle except that one.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wr_data,
    input  logic [2:0]  mem_funct3,
    output logic [31:0] mem_rd_data,
    output logic        mem_ready,
    output logic        mem_busy,
`ifdef DMEM_ACCESS_FAULT_EN
    output logic        mem_fault,
`endif
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        enter_resp;

    logic [31:0] addr_q, wdata_q;
    logic [2:0]  f3_q;
    logic        store_q;
    logic        fault_q;
    logic [31:0] rd_word_q;

    logic        req;
    logic [31:0] cur_addr, cur_wdata;
    logic [2:0]  cur_f3;
    logic        cur_store;
    logic        cur_fault;
    logic [AW-1:0] cur_idx;

    logic [3:0]  be;
    logic [31:0] wr_word, ld_data;

    assign req = mem_rd_en | mem_wr_en;

    // In IDLE the live inputs drive the datapath so LATENCY=1 can complete
    // on the acceptance edge; afterwards the latched copy is used.
    assign cur_addr  = (state == IDLE) ? mem_addr    : addr_q;
    assign cur_wdata = (state == IDLE) ? mem_wr_data : wdata_q;
    assign cur_f3    = (state == IDLE) ? mem_funct3  : f3_q;
    assign cur_store = (state == IDLE) ? mem_wr_en   : store_q;
    assign cur_idx   = cur_addr[2 +: AW];

`ifdef DMEM_ACCESS_FAULT_EN
    logic misalign;
    always_comb begin
        case (cur_f3)
            FUNCT3_B, FUNCT3_BU: misalign = 1'b0;
            FUNCT3_H, FUNCT3_HU: misalign = cur_addr[0];
            default:             misalign = |cur_addr[1:0];
        endcase
    end
    assign cur_fault = misalign | (|(cur_addr >> (AW + 2)));
`else
    assign cur_fault = 1'b0;
    // Upper address bits are deliberately ignored: accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^cur_addr[31:AW+2];
`endif

    dmem_lane_align u_align (
        .funct3  (cur_f3),
        .addr_lo (cur_addr[1:0]),
        .wr_data (cur_wdata),
        .rd_word (rd_word_q),
        .be      (be),
        .wr_word (wr_word),
        .ld_data (ld_data)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nxt = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    cnt_nxt    = 4'd0;
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            f3_q      <= 3'b000;
            store_q   <= 1'b0;
            fault_q   <= 1'b0;
            rd_word_q <= 32'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wr_data;
                f3_q    <= mem_funct3;
                store_q <= mem_wr_en;
            end
            if (enter_resp) begin
                fault_q   <= cur_fault;
                rd_word_q <= mem[cur_idx];
            end
        end
    end

    // Array contents are not reset; a reset before enter_resp drops the store.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_store && !cur_fault) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[cur_idx][8*k +: 8] <= wr_word[8*k +: 8];
            end
        end
    end

    assign mem_ready   = (state == RESP);
    assign mem_busy    = req & ~mem_ready;
    assign mem_rd_data = (mem_ready && !store_q && !fault_q) ? ld_data : 32'h0;
    assign dbg_state   = state;
`ifdef DMEM_ACCESS_FAULT_EN
    assign mem_fault   = mem_ready & fault_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] mem_addr, mem_wr_data;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rd_data;
    logic        mem_ready, mem_busy;
    logic        mem_fault;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rdata;
    logic        flt;

`ifndef DMEM_ACCESS_FAULT_EN
    assign mem_fault = 1'b0;
`endif

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LATENCY)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_funct3  (mem_funct3),
        .mem_rd_data (mem_rd_data),
        .mem_ready   (mem_ready),
        .mem_busy    (mem_busy),
`ifdef DMEM_ACCESS_FAULT_EN
        .mem_fault   (mem_fault),
`endif
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = 32'h0;
        mem_wr_data = 32'h0;
        mem_funct3  = 3'b000;
    endtask

    // One full request: hold until mem_ready, check latency, busy, and that
    // the ready pulse is exactly one cycle long.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f3,
                          output logic [31:0] rd_out, output logic flt_out);
        int lat;
        @(negedge clk);
        mem_rd_en   = rd;
        mem_wr_en   = wr;
        mem_addr    = a;
        mem_wr_data = d;
        mem_funct3  = f3;
        #1;
        check({tag, " busy_req"}, {31'b0, mem_busy}, 32'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!mem_ready && lat < 32);
        check({tag, " latency"}, 32'(lat), 32'(LATENCY));
        check({tag, " busy_ready"}, {31'b0, mem_busy}, 32'd0);
        rd_out  = mem_rd_data;
        flt_out = mem_fault;
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check({tag, " ready_pulse"}, {31'b0, mem_ready}, 32'd0);
        check({tag, " rd_data_idle"}, mem_rd_data, 32'h0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state with idle inputs
        @(posedge clk);
        #1;
        check("reset ready", {31'b0, mem_ready}, 32'd0);
        check("reset busy", {31'b0, mem_busy}, 32'd0);
        check("reset rd_data", mem_rd_data, 32'h0);
        check("reset state", {30'b0, dbg_state}, {30'b0, IDLE});
        check("reset fault", {31'b0, mem_fault}, 32'd0);

        // Word store then load
        access("sw10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, FUNCT3_W, rdata, flt);
        check("sw10 rd_data", rdata, 32'h0);
        access("lw10", 1'b1, 1'b0, 32'h10, 32'h0, FUNCT3_W, rdata, flt);
        check("lw10 rd_data", rdata, 32'hDEADBEEF);

        // Sub-word loads with extension
        access("sw80", 1'b0, 1'b1, 32'h80, 32'h000080F0, FUNCT3_W, rdata, flt);
        access("lb80", 1'b1, 1'b0, 32'h80, 32'h0, FUNCT3_B, rdata, flt);
        check("lb80 rd_data", rdata, 32'hFFFFFFF0);
        access("lbu81", 1'b1, 1'b0, 32'h81, 32'h0, FUNCT3_BU, rdata, flt);
        check("lbu81 rd_data", rdata, 32'h00000080);
        access("lh80", 1'b1, 1'b0, 32'h80, 32'h0, FUNCT3_H, rdata, flt);
        check("lh80 rd_data", rdata, 32'hFFFF80F0);
        access("lhu80", 1'b1, 1'b0, 32'h80, 32'h0, FUNCT3_HU, rdata, flt);
        check("lhu80 rd_data", rdata, 32'h000080F0);

        // Sub-word stores merge into the existing word
        access("sw20", 1'b0, 1'b1, 32'h20, 32'h11223344, FUNCT3_W, rdata, flt);
        access("sb23", 1'b0, 1'b1, 32'h23, 32'hFFFFFFAB, FUNCT3_B, rdata, flt);
        access("lw20a", 1'b1, 1'b0, 32'h20, 32'h0, FUNCT3_W, rdata, flt);
        check("sb23 merge", rdata, 32'hAB223344);
        access("sh22", 1'b0, 1'b1, 32'h22, 32'hFFFF5566, FUNCT3_H, rdata, flt);
        access("lw20b", 1'b1, 1'b0, 32'h20, 32'h0, FUNCT3_W, rdata, flt);
        check("sh22 merge", rdata, 32'h55663344);

        // Store wins when both enables are high
        access("rdwr0", 1'b1, 1'b1, 32'h0, 32'h1, FUNCT3_W, rdata, flt);
        check("rdwr0 rd_data", rdata, 32'h0);
        access("lw0", 1'b1, 1'b0, 32'h0, 32'h0, FUNCT3_W, rdata, flt);
        check("rdwr0 stored", rdata, 32'h1);

        // Reset during WAIT abandons the store
        access("sw4", 1'b0, 1'b1, 32'h4, 32'h12345678, FUNCT3_W, rdata, flt);
        @(negedge clk);
        mem_wr_en   = 1'b1;
        mem_addr    = 32'h4;
        mem_wr_data = 32'h7;
        mem_funct3  = FUNCT3_W;
        @(posedge clk);
        #1;
        check("abort in_wait", {30'b0, dbg_state}, {30'b0, WAIT});
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("abort state", {30'b0, dbg_state}, {30'b0, IDLE});
        check("abort ready", {31'b0, mem_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access("lw4", 1'b1, 1'b0, 32'h4, 32'h0, FUNCT3_W, rdata, flt);
        check("abort old_value", rdata, 32'h12345678);

`ifdef DMEM_ACCESS_FAULT_EN
        access("lw2f", 1'b1, 1'b0, 32'h2, 32'h0, FUNCT3_W, rdata, flt);
        check("lw2 fault", {31'b0, flt}, 32'd1);
        check("lw2 rd_data", rdata, 32'h0);
        access("sw1000f", 1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, FUNCT3_W, rdata, flt);
        check("sw1000 fault", {31'b0, flt}, 32'd1);
        access("lw0f", 1'b1, 1'b0, 32'h0, 32'h0, FUNCT3_W, rdata, flt);
        check("lw0 fault", {31'b0, flt}, 32'd0);
        check("word0 unchanged", rdata, 32'h1);
`else
        access("lw2", 1'b1, 1'b0, 32'h2, 32'h0, FUNCT3_W, rdata, flt);
        check("lw2 aligned_down", rdata, 32'h1);
        access("lh81", 1'b1, 1'b0, 32'h81, 32'h0, FUNCT3_H, rdata, flt);
        check("lh81 aligned_down", rdata, 32'hFFFF80F0);
        access("sw1000", 1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, FUNCT3_W, rdata, flt);
        access("lw0w", 1'b1, 1'b0, 32'h0, 32'h0, FUNCT3_W, rdata, flt);
        check("sw1000 wraps", rdata, 32'hCAFEF00D);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
